wb_port_arbiter: RTL

- Shares the single register-file write port between the in-order pipeline's writeback stage and a long-latency unit (divider / load-refill) that returns results out of band.
- Pipeline writes take priority. Long-latency results are buffered in a small FIFO.
- A starvation counter forces a one-cycle pipeline stall so buffered results drain.
- Exposes pending-destination lookups so the hazard unit can stall dependent decode-stage reads.

---
 rtl/wb_arb_pkg.sv | 19 +
 rtl/wb_ll_fifo.sv | 87 ++++++++
 rtl/wb_port_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types for the writeback-port arbiter: FSM states and the buffered
// long-latency result entry.
package wb_arb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;

  typedef enum logic {
    NORMAL = 1'b0,
    STALL  = 1'b1
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic [DEF_REG_AW-1:0] rd;
    logic [DEF_DATA_W-1:0] data;
  } ll_entry_t;

endpackage

// File: rtl/wb_ll_fifo.sv
// Circular buffer of long-latency results with per-entry valid bits,
// squash-by-destination and two destination lookup ports.
module wb_ll_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  ll_entry_t             push_entry,
  input  logic                  pop,
  input  logic                  squash_en,
  input  logic [DEF_REG_AW-1:0] squash_rd,
  input  logic [DEF_REG_AW-1:0] match_rd1,
  input  logic [DEF_REG_AW-1:0] match_rd2,
  output ll_entry_t             head,
  output logic                  full,
  output logic                  empty,
  output logic                  match1,
  output logic                  match2
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0]      vld;
  logic [DEF_REG_AW-1:0] rd_mem   [DEPTH];
  logic [DEF_DATA_W-1:0] data_mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    head.valid = vld[rd_ptr];
    head.rd    = rd_mem[rd_ptr];
    head.data  = data_mem[rd_ptr];
  end

  // Lookups see registered state only; a same-cycle push is invisible.
  always_comb begin
    match1 = 1'b0;
    match2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && rd_mem[i] == match_rd1) match1 = 1'b1;
      if (vld[i] && rd_mem[i] == match_rd2) match2 = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (squash_en && vld[i] && rd_mem[i] == squash_rd) vld[i] <= 1'b0;
      end
      if (pop_ok) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + AW'(1);
      end
      // The pushed slot is never live, so it cannot collide with squash or pop.
      if (push_ok) begin
        vld[wr_ptr] <= push_entry.valid;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      rd_mem[wr_ptr]   <= push_entry.rd;
      data_mem[wr_ptr] <= push_entry.data;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, long-latency
// results are buffered and drained, with a forced stall on starvation. Optional
// zero-latency LL bypass when WB_LL_BYPASS_EN is defined.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int REG_AW     = DEF_REG_AW,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite_W,
  input  logic [REG_AW-1:0] rd_W,
  input  logic [DATA_W-1:0] Result_W,
  input  logic              LL_valid,
  input  logic [REG_AW-1:0] LL_rd,
  input  logic [DATA_W-1:0] LL_data,
  output logic              LL_ready,
  output logic              Stall_W,
  input  logic [REG_AW-1:0] rs1_D,
  input  logic [REG_AW-1:0] rs2_D,
  output logic              rs1_pending,
  output logic              rs2_pending,
  output logic              RegWrite_out,
  output logic [REG_AW-1:0] rd_out,
  output logic [DATA_W-1:0] WD3_out
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  state_t            state;
  logic [SW-1:0]     starve_cnt;
  ll_entry_t         head;
  ll_entry_t         push_entry;
  logic              full;
  logic              empty;
  logic              match1;
  logic              match2;
  logic              pipe_act;
  logic              pop;
  logic              push;
  logic              squash;
  logic              bypass;
  logic              we;
  logic [REG_AW-1:0] wa;
  logic [DATA_W-1:0] wd;

  assign pipe_act = RegWrite_W && (rd_W != '0);

  always_comb begin
    we     = 1'b0;
    wa     = '0;
    wd     = '0;
    pop    = 1'b0;
    squash = 1'b0;
    bypass = 1'b0;
    if (state == STALL) begin
      // Pipeline inputs are ignored; a squashed head pops without writing.
      pop = !empty;
      we  = !empty && head.valid;
      wa  = head.rd;
      wd  = head.data;
    end else if (pipe_act) begin
      we     = 1'b1;
      wa     = rd_W;
      wd     = Result_W;
      squash = 1'b1;
    end else if (!empty) begin
      pop = 1'b1;
      we  = head.valid;
      wa  = head.rd;
      wd  = head.data;
`ifdef WB_LL_BYPASS_EN
    end else if (LL_valid && LL_rd != '0) begin
      bypass = 1'b1;
      we     = 1'b1;
      wa     = LL_rd;
      wd     = LL_data;
`endif
    end
  end

  // rd 0 and same-cycle WAW targets are accepted by the handshake but dropped.
  assign push = LL_valid && !full && (LL_rd != '0) && !bypass &&
                !(squash && LL_rd == rd_W);

  always_comb begin
    push_entry.valid = 1'b1;
    push_entry.rd    = LL_rd;
    push_entry.data  = LL_data;
  end

  wb_ll_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .squash_en  (squash),
    .squash_rd  (rd_W),
    .match_rd1  (rs1_D),
    .match_rd2  (rs2_D),
    .head       (head),
    .full       (full),
    .empty      (empty),
    .match1     (match1),
    .match2     (match2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= NORMAL;
      starve_cnt <= '0;
    end else begin
      case (state)
        STALL: begin
          state      <= NORMAL;
          starve_cnt <= '0;
        end
        default: begin
          if (empty || pop) begin
            starve_cnt <= '0;
          end else begin
            if (starve_cnt == SW'(STARVE_MAX - 1)) state <= STALL;
            starve_cnt <= starve_cnt + SW'(1);
          end
        end
      endcase
    end
  end

  assign RegWrite_out = !rst && we;
  assign rd_out       = rst ? '0 : wa;
  assign WD3_out      = rst ? '0 : wd;
  assign Stall_W      = !rst && (state == STALL);
  assign LL_ready     = !rst && !full;
  assign rs1_pending  = !rst && (rs1_D != '0) && match1;
  assign rs2_pending  = !rst && (rs2_D != '0) && match2;

endmodule
